// File: rtl/fluxo_pkg.sv
// Shared definitions for the multiplier datapath and its controller:
// state encoding, default operand widths and the {SAIDA,LOAD} command encoding.
package fluxo_pkg;

    localparam int N_DEF = 8;
    localparam int M_DEF = 8;

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        SOMANDO   = 2'b01,
        CONCLUIDO = 2'b10
    } estado_t;

    // Bit 1 is SAIDA, bit 0 is LOAD; both set means LOAD wins.
    typedef enum logic [1:0] {
        CMD_NADA  = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_SAIDA = 2'b10,
        CMD_AMBOS = 2'b11
    } comando_t;

endpackage

// File: rtl/fluxo_dados.sv
// Repeated-addition multiplier datapath: loads A/B, adds B into the accumulator
// while AR counts down, and publishes the product on the SAIDA command.
module fluxo_dados
    import fluxo_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           LOAD,
    input  logic           SAIDA,
    input  logic [N-1:0]   A,
    input  logic [M-1:0]   B,
    output logic [N-1:0]   AR,
    output logic [N+M-1:0] RESULTADO,
    output logic           VALIDO,
    output logic           OCUPADO,
    output logic           ERRO
);

    estado_t          state_reg, state_next;
    logic [N-1:0]     ar_reg, ar_next;
    logic [M-1:0]     br_reg, br_next;
    logic [N+M-1:0]   acc_reg, acc_next;
    logic [N+M-1:0]   resultado_reg, resultado_next;
    logic             valido_reg, valido_next;
    logic             ocupado_reg, ocupado_next;
    logic             erro_reg, erro_next;
    comando_t         cmd;

    assign cmd = comando_t'({SAIDA, LOAD});

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= OCIOSO;
            ar_reg        <= '0;
            br_reg        <= '0;
            acc_reg       <= '0;
            resultado_reg <= '0;
            valido_reg    <= 1'b0;
            ocupado_reg   <= 1'b0;
            erro_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ar_reg        <= ar_next;
            br_reg        <= br_next;
            acc_reg       <= acc_next;
            resultado_reg <= resultado_next;
            valido_reg    <= valido_next;
            ocupado_reg   <= ocupado_next;
            erro_reg      <= erro_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ar_next        = ar_reg;
        br_next        = br_reg;
        acc_next       = acc_reg;
        resultado_next = resultado_reg;
        valido_next    = 1'b0;
        erro_next      = erro_reg;

        case (cmd)
            CMD_LOAD, CMD_AMBOS: begin
                ar_next    = A;
                br_next    = B;
                acc_next   = '0;
                erro_next  = 1'b0;
                state_next = SOMANDO;
            end
            CMD_SAIDA: begin
                if (state_reg == SOMANDO) begin
                    // Publishing early is flagged but the partial sum still goes out.
                    resultado_next = acc_reg;
                    valido_next    = 1'b1;
                    if (ar_reg != '0)
                        erro_next = 1'b1;
                    state_next = CONCLUIDO;
                end
            end
            default: begin
                if (state_reg == SOMANDO && ar_reg != '0) begin
                    acc_next = acc_reg + (N+M)'(br_reg);
                    ar_next  = ar_reg - 1'b1;
                end
            end
        endcase

        ocupado_next = (state_next == SOMANDO);
    end

    assign AR        = ar_reg;
    assign RESULTADO = resultado_reg;
    assign VALIDO    = valido_reg;
    assign OCUPADO   = ocupado_reg;
    assign ERRO      = erro_reg;

endmodule

// File: tb/tb_fluxo_dados.sv
// Scoreboard bench for fluxo_dados: every SAIDA publication queues its expected
// product/error, and a monitor pops one entry per VALIDO pulse.
module tb_fluxo_dados;

    localparam int N = 8;
    localparam int M = 8;

    typedef struct {
        logic [N+M-1:0] res;
        logic           erro;
    } esperado_t;

    logic           CLK = 1'b0;
    logic           RESET = 1'b0;
    logic           LOAD = 1'b0;
    logic           SAIDA = 1'b0;
    logic [N-1:0]   A = '0;
    logic [M-1:0]   B = '0;
    logic [N-1:0]   AR;
    logic [N+M-1:0] RESULTADO;
    logic           VALIDO;
    logic           OCUPADO;
    logic           ERRO;

    esperado_t fila[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_pulsos = 0;

    fluxo_dados #(.N(N), .M(M)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .LOAD      (LOAD),
        .SAIDA     (SAIDA),
        .A         (A),
        .B         (B),
        .AR        (AR),
        .RESULTADO (RESULTADO),
        .VALIDO    (VALIDO),
        .OCUPADO   (OCUPADO),
        .ERRO      (ERRO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cmd_load(input logic [N-1:0] a, input logic [M-1:0] b, input logic com_saida);
        A = a; B = b; LOAD = 1'b1; SAIDA = com_saida;
        tick();
        LOAD = 1'b0; SAIDA = 1'b0;
    endtask

    task automatic ocioso(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic publica(input logic [N+M-1:0] res, input logic erro, input int ciclos);
        esperado_t e;
        e.res = res;
        e.erro = erro;
        fila.push_back(e);
        SAIDA = 1'b1;
        for (int i = 0; i < ciclos; i++) tick();
        SAIDA = 1'b0;
    endtask

    // Monitor: each VALIDO pulse consumes exactly one queued expectation.
    always @(negedge CLK) begin
        if (VALIDO === 1'b1) begin
            esperado_t e;
            n_pulsos++;
            if (fila.size() == 0) begin
                check("valido_inesperado", 32'd1, 32'd0);
            end else begin
                e = fila.pop_front();
                check("resultado", 32'(RESULTADO), 32'(e.res));
                check("erro_no_valido", 32'(ERRO), 32'(e.erro));
            end
        end
    end

    initial begin
        // Reset and idle
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        ocioso(3);
        check("rst_ar", 32'(AR), 0);
        check("rst_resultado", 32'(RESULTADO), 0);
        check("rst_valido", 32'(VALIDO), 0);
        check("rst_ocupado", 32'(OCUPADO), 0);
        check("rst_erro", 32'(ERRO), 0);

        // 5 x 7: AR counts 5..0
        cmd_load(8'd5, 8'd7, 1'b0);
        check("ar_carga5", 32'(AR), 5);
        check("ocupado_somando", 32'(OCUPADO), 1);
        for (int k = 4; k >= 0; k--) begin
            tick();
            check($sformatf("ar_conta%0d", k), 32'(AR), 32'(k));
        end
        publica(16'd35, 1'b0, 1);
        check("valido_um_ciclo", 32'(VALIDO), 1);
        tick();
        check("valido_baixa", 32'(VALIDO), 0);
        check("ocupado_concluido", 32'(OCUPADO), 0);

        // 255 x 255 with SAIDA held 4 cycles: one pulse, AR stays 0
        cmd_load(8'd255, 8'd255, 1'b0);
        ocioso(255);
        check("ar_zero_255", 32'(AR), 0);
        ocioso(3);
        check("ar_sem_wrap", 32'(AR), 0);
        publica(16'd65025, 1'b0, 4);
        check("ar_apos_saida", 32'(AR), 0);
        check("resultado_mantido", 32'(RESULTADO), 65025);

        // A = 0: publish right after the load
        cmd_load(8'd0, 8'd9, 1'b0);
        check("ar_a_zero", 32'(AR), 0);
        publica(16'd0, 1'b0, 1);

        // Early publish: partial sum with error flag
        cmd_load(8'd6, 8'd3, 1'b0);
        ocioso(2);
        check("ar_parcial", 32'(AR), 4);
        publica(16'd6, 1'b1, 1);
        tick();
        check("erro_pegajoso", 32'(ERRO), 1);

        // New load clears the error; reset mid-run clears everything at once
        cmd_load(8'd10, 8'd4, 1'b0);
        check("erro_limpo_load", 32'(ERRO), 0);
        ocioso(3);
        check("ar_antes_reset", 32'(AR), 7);
        RESET = 1'b1;
        #2;
        check("rst_async_ar", 32'(AR), 0);
        check("rst_async_resultado", 32'(RESULTADO), 0);
        check("rst_async_ocupado", 32'(OCUPADO), 0);
        RESET = 1'b0;
        tick();

        // LOAD+SAIDA together while summing: load wins, no VALIDO
        cmd_load(8'd2, 8'd4, 1'b0);
        tick();
        check("ar_antes_ambos", 32'(AR), 1);
        cmd_load(8'd2, 8'd4, 1'b1);
        check("ar_load_ambos", 32'(AR), 2);
        check("valido_ambos", 32'(VALIDO), 0);
        ocioso(2);
        check("ar_fim_2", 32'(AR), 0);
        publica(16'd8, 1'b0, 1);
        ocioso(3);

        check("fila_vazia", 32'(fila.size()), 0);
        check("total_pulsos", 32'(n_pulsos), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
